// File: rtl/matrix_operand_buffer_if.sv
// Bus bundle between the matrix operand buffer and its neighbours: the load
// control and write stream on one side, and the extractor read port on the other.
interface matrix_operand_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 8,
    parameter int WW         = 5
);
    logic                  load_start;
    logic [AW-1:0]         base_addr_in;
    logic [WW-1:0]         matrix_width_in;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  load_done;
    logic                  buf_ready;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  rd_op;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    // Producer / extractor side.
    modport master (
        output load_start, base_addr_in, matrix_width_in, wr_data, wr_valid,
        output rd_en, rd_addr, rd_op,
        input  wr_ready, load_done, buf_ready, data_out, valid_out
    );

    // Buffer side.
    modport slave (
        input  load_start, base_addr_in, matrix_width_in, wr_data, wr_valid,
        input  rd_en, rd_addr, rd_op,
        output wr_ready, load_done, buf_ready, data_out, valid_out
    );
endinterface

// File: rtl/matrix_operand_buffer.sv
// Matrix-A operand store: loads one N x N matrix row-major into RAM starting at
// a programmable base address (wrapping modulo the RAM depth), then serves the
// extractor's address requests with 1-cycle registered read data.
module matrix_operand_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIF0_DEPTH = 256,
    parameter int DATA_DEPTH = 256
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    rst_flush,
    matrix_operand_buffer_if.slave bus
);
    function automatic int isqrt(input int v);
        int r;
        r = 0;
        for (int i = 0; i <= v; i++) begin
            if (i * i <= v) r = i;
        end
        return r;
    endfunction

    localparam int AW = $clog2(FIF0_DEPTH);
    localparam int WW = $clog2(isqrt(DATA_DEPTH)) + 1;
    // Element count width: holds N*N up to DATA_DEPTH without truncation.
    localparam int CW = $clog2(DATA_DEPTH) + 1;
    localparam int SW = ((AW > CW) ? AW : CW) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] READY   = 2'd2;

    logic [1:0]            state;
    logic [AW-1:0]         base;
    logic [CW-1:0]         total;
    logic [CW-1:0]         wcnt;
    logic                  done_pulse;
    logic [CW-1:0]         new_total;
    logic                  start_ok;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [SW-1:0]         wr_sum;
    logic [AW-1:0]         wr_addr;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [DATA_WIDTH-1:0] mem [FIF0_DEPTH];

    // A zero-width request is dropped; otherwise total is the full N*N.
    assign start_ok  = bus.load_start && (bus.matrix_width_in != '0);
    assign new_total = CW'(bus.matrix_width_in) * CW'(bus.matrix_width_in);

    assign wr_fire = (state == LOADING) && bus.wr_valid;
    assign rd_fire = (state == READY) && bus.rd_en && !bus.rd_op;

    // Row-major element index offset from base, wrapped around the RAM.
    assign wr_sum  = SW'(base) + SW'(wcnt);
    assign wr_addr = AW'(wr_sum % SW'(FIF0_DEPTH));

    assign bus.wr_ready  = (state == LOADING);
    assign bus.buf_ready = (state == READY);
    assign bus.load_done = done_pulse;
    assign bus.data_out  = data_p1;
    assign bus.valid_out = vld_p1;

    // Load FSM: IDLE -> LOADING on a start, LOADING -> READY after the last element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            total      <= '0;
            wcnt       <= '0;
            done_pulse <= 1'b0;
        end else if (rst_flush) begin
            state      <= IDLE;
            wcnt       <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (start_ok) begin
                        base  <= bus.base_addr_in;
                        total <= new_total;
                        wcnt  <= '0;
                        state <= LOADING;
                    end
                end
                LOADING: begin
                    // Further load_start requests are ignored until the load finishes.
                    if (wr_fire) begin
                        wcnt <= wcnt + CW'(1);
                        if (wcnt == total - CW'(1)) begin
                            done_pulse <= 1'b1;
                            state      <= READY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM write port; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= bus.wr_data;
    end

    // ---- stage p1: registered read data and its valid strobe ----
    // Out-of-range addresses return raw RAM content; the extractor pads with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (rst_flush) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) data_p1 <= mem[bus.rd_addr];
        end
    end
endmodule

// File: tb/tb_matrix_operand_buffer.sv
// Directed bench for matrix_operand_buffer: reset/flush, 4x4 load, read latency,
// write gaps, wrap-around full-size load, ignored events, read during restart.
module tb_matrix_operand_buffer;
    logic clk;
    logic rst_n;
    logic rst_flush;
    int   checks;
    int   errors;

    matrix_operand_buffer_if #(.DATA_WIDTH(32), .AW(8), .WW(5)) bus ();

    matrix_operand_buffer #(
        .DATA_WIDTH(32),
        .FIF0_DEPTH(256),
        .DATA_DEPTH(256)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_flush(rst_flush),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [4:0] n);
        bus.base_addr_in    = base;
        bus.matrix_width_in = n;
        bus.load_start      = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %0b exp 0", bus.wr_ready); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done got %0b exp 0", bus.load_done); end
        checks++; if (bus.buf_ready !== 1'b0) begin errors++; $display("FAIL rst_buf_ready got %0b exp 0", bus.buf_ready); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out got %0b exp 0", bus.valid_out); end
        checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL rst_data_out got %0d exp 0", bus.data_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_4x4();
        int pulses;
        pulses = 0;
        start_load(8'd8, 5'd4);
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL l4_wr_ready got %0b exp 1", bus.wr_ready); end
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'(100 + i);
            tick();
            if (bus.load_done === 1'b1) pulses++;
            if (i < 15 && bus.wr_ready !== 1'b1) begin
                errors++; $display("FAIL l4_wr_ready_mid got %0b exp 1 at %0d", bus.wr_ready, i);
            end
        end
        bus.wr_valid = 1'b0;
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL l4_done_after16 got %0b exp 1", bus.load_done); end
        checks++; if (bus.buf_ready !== 1'b1) begin errors++; $display("FAIL l4_buf_ready got %0b exp 1", bus.buf_ready); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL l4_wr_ready_end got %0b exp 0", bus.wr_ready); end
        tick();
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL l4_done_drop got %0b exp 0", bus.load_done); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL l4_done_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_read_latency();
        bus.rd_en = 1'b1; bus.rd_op = 1'b0; bus.rd_addr = 8'd8;
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd100) begin errors++; $display("FAIL rd8 got %0b/%0d exp 1/100", bus.valid_out, bus.data_out); end
        bus.rd_addr = 8'd9;
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd101) begin errors++; $display("FAIL rd9 got %0b/%0d exp 1/101", bus.valid_out, bus.data_out); end
        bus.rd_addr = 8'd23;
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd115) begin errors++; $display("FAIL rd23 got %0b/%0d exp 1/115", bus.valid_out, bus.data_out); end
        bus.rd_en = 1'b0;
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 32'd115) begin errors++; $display("FAIL rd_idle got %0b/%0d exp 0/115", bus.valid_out, bus.data_out); end
    endtask

    task automatic test_rd_op();
        bus.rd_en = 1'b1; bus.rd_op = 1'b1; bus.rd_addr = 8'd9;
        tick();
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 32'd115) begin errors++; $display("FAIL rdop got %0b/%0d exp 0/115", bus.valid_out, bus.data_out); end
        bus.rd_en = 1'b0; bus.rd_op = 1'b0;
    endtask

    task automatic test_async_reset_retain();
        bus.rd_en = 1'b1; bus.rd_addr = 8'd9;
        tick();
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.buf_ready !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 32'd0) begin
            errors++; $display("FAIL async_rst got %0b/%0b/%0d exp 0/0/0", bus.buf_ready, bus.valid_out, bus.data_out);
        end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.buf_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin errors++; $display("FAIL async_idle got %0b/%0b exp 0/0", bus.buf_ready, bus.wr_ready); end
        start_load(8'd0, 5'd1);
        bus.wr_valid = 1'b1; bus.wr_data = 32'd7;
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (bus.load_done !== 1'b1 || bus.buf_ready !== 1'b1) begin errors++; $display("FAIL n1_done got %0b/%0b exp 1/1", bus.load_done, bus.buf_ready); end
        bus.rd_en = 1'b1; bus.rd_addr = 8'd9;
        tick();
        checks++; if (bus.data_out !== 32'd101) begin errors++; $display("FAIL retain_rd9 got %0d exp 101", bus.data_out); end
        bus.rd_addr = 8'd0;
        tick();
        checks++; if (bus.data_out !== 32'd7) begin errors++; $display("FAIL n1_rd0 got %0d exp 7", bus.data_out); end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        int pulses;
        int done_c;
        acc = 0; pulses = 0; done_c = -1;
        start_load(8'd40, 5'd3);
        for (int c = 0; c < 20; c++) begin
            bus.wr_valid = (c % 2 == 0);
            bus.wr_data  = bus.wr_valid ? 32'(200 + acc) : 32'hDEAD_BEEF;
            if (bus.wr_valid) acc++;
            if (bus.wr_ready !== (c <= 16)) begin
                errors++; $display("FAIL bp_wr_ready got %0b exp %0b at %0d", bus.wr_ready, (c <= 16), c);
            end
            tick();
            if (bus.load_done === 1'b1) begin pulses++; done_c = c; end
        end
        bus.wr_valid = 1'b0;
        checks++; if (pulses !== 1 || done_c !== 16) begin errors++; $display("FAIL bp_done got %0d@%0d exp 1@16", pulses, done_c); end
        bus.rd_en = 1'b1; bus.rd_addr = 8'd44;
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd204) begin errors++; $display("FAIL bp_rd44 got %0b/%0d exp 1/204", bus.valid_out, bus.data_out); end
        bus.rd_addr = 8'd48;
        tick();
        checks++; if (bus.data_out !== 32'd208) begin errors++; $display("FAIL bp_rd48 got %0d exp 208", bus.data_out); end
    endtask

    task automatic test_flush();
        bus.rd_en = 1'b1; bus.rd_addr = 8'd44; rst_flush = 1'b1;
        tick();
        rst_flush = 1'b0; bus.rd_en = 1'b0;
        checks++; if (bus.buf_ready !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 32'd0) begin
            errors++; $display("FAIL flush got %0b/%0b/%0d exp 0/0/0", bus.buf_ready, bus.valid_out, bus.data_out);
        end
        start_load(8'd0, 5'd0);
        checks++; if (bus.wr_ready !== 1'b0 || bus.buf_ready !== 1'b0) begin errors++; $display("FAIL n0_ignored got %0b/%0b exp 0/0", bus.wr_ready, bus.buf_ready); end
        start_load(8'd60, 5'd2);
        bus.wr_valid = 1'b1; bus.wr_data = 32'd77;
        tick();
        bus.wr_valid = 1'b0; rst_flush = 1'b1;
        tick();
        rst_flush = 1'b0;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL flush_midload got %0b exp 0", bus.wr_ready); end
        start_load(8'd70, 5'd1);
        bus.wr_valid = 1'b1; bus.wr_data = 32'd88;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_en = 1'b1; bus.rd_addr = 8'd60;
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd77) begin errors++; $display("FAIL partial_rd60 got %0b/%0d exp 1/77", bus.valid_out, bus.data_out); end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_wrap_full();
        int pulses;
        pulses = 0;
        start_load(8'd250, 5'd16);
        for (int i = 0; i < 256; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'(1000 + i);
            tick();
            if (bus.load_done === 1'b1) begin
                pulses++;
                if (i != 255) begin errors++; $display("FAIL wrap_early_done got 1 exp 0 at %0d", i); end
            end
        end
        bus.wr_valid = 1'b0;
        checks++; if (pulses !== 1 || bus.buf_ready !== 1'b1) begin errors++; $display("FAIL wrap_done got %0d/%0b exp 1/1", pulses, bus.buf_ready); end
        bus.rd_en = 1'b1; bus.rd_addr = 8'd0;
        tick();
        checks++; if (bus.data_out !== 32'd1006) begin errors++; $display("FAIL wrap_rd0 got %0d exp 1006", bus.data_out); end
        bus.rd_addr = 8'd250;
        tick();
        checks++; if (bus.data_out !== 32'd1000) begin errors++; $display("FAIL wrap_rd250 got %0d exp 1000", bus.data_out); end
        bus.rd_addr = 8'd255;
        tick();
        checks++; if (bus.data_out !== 32'd1005) begin errors++; $display("FAIL wrap_rd255 got %0d exp 1005", bus.data_out); end
        bus.rd_addr = 8'd249;
        tick();
        checks++; if (bus.data_out !== 32'd1255) begin errors++; $display("FAIL wrap_rd249 got %0d exp 1255", bus.data_out); end
        bus.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        start_load(8'd100, 5'd2);
        checks++; if (bus.buf_ready !== 1'b0 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reload got %0b/%0b exp 0/1", bus.buf_ready, bus.wr_ready); end
        bus.rd_en = 1'b1; bus.rd_addr = 8'd100;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 32'(300 + i);
            tick();
            checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL ld_rd_vld got %0b exp 0", bus.valid_out); end
        end
        bus.load_start = 1'b1; bus.base_addr_in = 8'd0; bus.matrix_width_in = 5'd3;
        bus.wr_data = 32'd302;
        tick();
        bus.load_start = 1'b0;
        checks++; if (bus.load_done !== 1'b0 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL ld_restart got %0b/%0b exp 0/1", bus.load_done, bus.wr_ready); end
        bus.wr_data = 32'd303;
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (bus.load_done !== 1'b1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL ld_finish got %0b/%0b exp 1/0", bus.load_done, bus.valid_out); end
        bus.rd_addr = 8'd103;
        tick();
        checks++; if (bus.data_out !== 32'd303) begin errors++; $display("FAIL ign_rd103 got %0d exp 303", bus.data_out); end
        bus.rd_addr = 8'd0;
        tick();
        checks++; if (bus.data_out !== 32'd1006) begin errors++; $display("FAIL ign_rd0 got %0d exp 1006", bus.data_out); end
    endtask

    task automatic test_read_and_load();
        bus.rd_en = 1'b1; bus.rd_addr = 8'd101;
        bus.load_start = 1'b1; bus.base_addr_in = 8'd120; bus.matrix_width_in = 5'd1;
        tick();
        bus.load_start = 1'b0;
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd301) begin errors++; $display("FAIL rl_rd got %0b/%0d exp 1/301", bus.valid_out, bus.data_out); end
        checks++; if (bus.wr_ready !== 1'b1 || bus.buf_ready !== 1'b0) begin errors++; $display("FAIL rl_state got %0b/%0b exp 1/0", bus.wr_ready, bus.buf_ready); end
        bus.rd_addr = 8'd120;
        bus.wr_valid = 1'b1; bus.wr_data = 32'd55;
        tick();
        bus.wr_valid = 1'b0;
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 32'd301 || bus.load_done !== 1'b1) begin
            errors++; $display("FAIL rl_load got %0b/%0d/%0b exp 0/301/1", bus.valid_out, bus.data_out, bus.load_done);
        end
        tick();
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd55) begin errors++; $display("FAIL rl_rd120 got %0b/%0d exp 1/55", bus.valid_out, bus.data_out); end
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; rst_flush = 1'b0;
        bus.load_start = 1'b0; bus.base_addr_in = '0; bus.matrix_width_in = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_op = 1'b0;
        test_reset();
        test_load_4x4();
        test_read_latency();
        test_rd_op();
        test_async_reset_retain();
        test_backpressure();
        test_flush();
        test_wrap_full();
        test_ignored();
        test_read_and_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_operand_buffer.md
Name: matrix_operand_buffer

Overview:
- Operand store sitting directly upstream of the matrix-A data extractor.
- Loads one square matrix, row-major, from a valid/ready write stream into on-chip RAM starting at a programmable base address.
- Once loaded, serves the extractor's address requests (fifo_addr / fifo_operation) with registered read data plus a valid strobe, which drive the extractor's data_in / valid_in.
- Status is tracked by a small load FSM.

Parameters:
- DATA_WIDTH, 32, element width in bits.
- FIF0_DEPTH, 256, number of RAM words; address width AW = $clog2(FIF0_DEPTH).
- DATA_DEPTH, 256, maximum element count of one matrix; width port WW = $clog2(int'(DATA_DEPTH**0.5))+1 bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rst_flush  in  1  synchronous flush; same state effect as reset.
- load_start  in  1  single-cycle request to begin loading a matrix.
- base_addr_in  in  AW  RAM address of element (0,0); captured at load_start.
- matrix_width_in  in  WW  matrix side N (1..sqrt(DATA_DEPTH)); captured at load_start.
- wr_data  in  DATA_WIDTH  element being written.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  buffer accepts wr_data this cycle.
- load_done  out  1  one-cycle pulse when the last element is written.
- buf_ready  out  1  high while the matrix is resident and readable (READY state).
- rd_en  in  1  read request enable (extractor enable).
- rd_addr  in  AW  read address (extractor fifo_addr).
- rd_op  in  1  0 = read, 1 = reserved (ignored, no access).
- data_out  out  DATA_WIDTH  read data (to extractor data_in).
- valid_out  out  1  data_out valid (to extractor valid_in).

Behaviour:
- Reset (rst_n low, asynchronous) and rst_flush (synchronous, any state):
  - State goes to IDLE.
  - wr_ready=0, load_done=0, buf_ready=0, valid_out=0, data_out=0.
  - Write count cleared.
  - RAM contents are not cleared.
- FSM states IDLE, LOADING, READY:
  - IDLE: on load_start, capture base_addr_in -> base, N -> width, compute total = N*N (9 bits, no truncation for N=16), clear wcnt, go LOADING.
  - LOADING: wr_ready=1. A write occurs when wr_valid & wr_ready: RAM[(base + wcnt) mod FIF0_DEPTH] <= wr_data, wcnt++. The address wraps modulo FIF0_DEPTH.
  - LOADING exit: on the write where wcnt == total-1, assert load_done for that next cycle, deassert wr_ready the next cycle, go READY.
  - READY: buf_ready=1, wr_ready=0. On load_start, return to LOADING with the new base and width; buf_ready drops the next cycle.
- load_start in LOADING is ignored.
- N=0 at load_start: the request is ignored and the state stays IDLE.
- Reads:
  - Read issue condition: state READY, rd_en=1 and rd_op=0.
  - A read issued at cycle t produces data_out = RAM[rd_addr] and valid_out=1 at cycle t+1.
  - 1-cycle latency, one read per cycle, fully pipelined.
  - When the issue condition is false, valid_out=0 next cycle and data_out holds its last value.
- Reads outside [base, base+total) are permitted and return raw RAM content. The extractor's edge padding relies on this.
- A read and a load_start in the same READY cycle: the read is still serviced (valid_out=1 next cycle); the state then moves to LOADING.
- No read is serviced during LOADING or IDLE.
- Flush mid-load: partial data remains in RAM, state goes to IDLE, and a new load_start is required.

Test Plan:
- Reset / flush:
  - Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
  - Release, then pulse rst_flush in READY -> buf_ready=0 next cycle, state IDLE.
- 4x4 load: load_start with base=8, N=4, then 16 writes of values 100..115 with wr_valid continuous.
  - load_done pulses exactly once, the cycle after the 16th write.
  - buf_ready=1; wr_ready=0 thereafter.
- Read latency: after the 4x4 load, rd_en=1 with rd_addr 8,9,23 on consecutive cycles.
  - data_out = 100, 101, 115 on the following cycles, each with valid_out=1.
  - rd_en=0 -> valid_out=0 one cycle later.
- Backpressure / gaps: load N=3 with wr_valid toggling 1,0,1,...
  - Only 9 accepted writes.
  - load_done after the 9th; rd_addr=base+4 returns the 5th value.
- Wrap and full size: base=250, N=16.
  - 256 writes land at 250..255 then 0..249.
  - rd_addr=0 returns the 7th element; total count 256 is reached without overflow.
- Ignored events:
  - load_start during LOADING -> no restart (wcnt continues).
  - rd_en during LOADING -> valid_out stays 0.
  - rd_op=1 in READY -> valid_out=0.
